// File: rtl/uart_alu_engine.sv
// Byte-stream arithmetic engine for the osdvu uart core: receives opcode + two operands,
// computes the result and streams back an optional operand echo, the result and a flags byte.
module uart_alu_engine #(
  parameter int OPERAND_BYTES  = 2,
  parameter int ECHO           = 1,
  parameter int TIMEOUT_CYCLES = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_strobe,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       frame_error
);

  localparam int W         = 8 * OPERAND_BYTES;
  localparam int SEQ_BYTES = (ECHO != 0) ? (3 * OPERAND_BYTES + 1) : (OPERAND_BYTES + 1);
  localparam int SEQ_W     = 8 * SEQ_BYTES;
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0]      LAST_BYTE = 3'(OPERAND_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]      TX_LAST   = 4'(SEQ_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_A,
    RX_B,
    CALC,
    TX_LOAD,
    TX_WAIT_HI,
    TX_WAIT_LO
  } state_t;

  state_t            state_q;
  logic [2:0]        opcode_q;
  logic [W-1:0]      opA_q;
  logic [W-1:0]      opB_q;
  logic [2:0]        byteCnt_q;
  logic [TO_W-1:0]   toCnt_q;
  logic [SEQ_W-1:0]  txShift_q;
  logic [3:0]        txLeft_q;
  logic [7:0]        txByte_q;
  logic              busy_q;
  logic              frameError_q;

  logic [W:0]        sum_d;
  logic [W-1:0]      result_d;
  logic              carry_d;
  logic [7:0]        flags_d;
  logic [SEQ_W-1:0]  seqInit_d;

  always_comb begin
    sum_d    = {1'b0, opA_q} + {1'b0, opB_q};
    result_d = '0;
    carry_d  = 1'b0;
    case (opcode_q)
      3'd0: begin
        result_d = sum_d[W-1:0];
        carry_d  = sum_d[W];
      end
      3'd1: begin
        result_d = opA_q - opB_q;
        carry_d  = (opA_q < opB_q);
      end
      3'd2:    result_d = opA_q & opB_q;
      3'd3:    result_d = opA_q | opB_q;
      3'd4:    result_d = opA_q ^ opB_q;
      default: result_d = '0;
    endcase
    flags_d = {carry_d, (result_d == '0), 6'b0};
  end

  // The whole response is packed MSB-first so transmission is a plain left shift.
  generate
    if (ECHO != 0) begin : g_echo
      assign seqInit_d = {opA_q, opB_q, result_d, flags_d};
    end else begin : g_noecho
      assign seqInit_d = {result_d, flags_d};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      opcode_q     <= '0;
      opA_q        <= '0;
      opB_q        <= '0;
      byteCnt_q    <= '0;
      toCnt_q      <= '0;
      txShift_q    <= '0;
      txLeft_q     <= '0;
      txByte_q     <= '0;
      busy_q       <= 1'b0;
      frameError_q <= 1'b0;
    end else begin
      frameError_q <= 1'b0;
      busy_q       <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (rx_strobe) begin
            if (rx_data <= 8'h04) begin
              opcode_q  <= rx_data[2:0];
              opA_q     <= '0;
              opB_q     <= '0;
              byteCnt_q <= '0;
              toCnt_q   <= '0;
              state_q   <= RX_A;
            end else begin
              txByte_q <= 8'hEE;
              txLeft_q <= '0;
              state_q  <= TX_LOAD;
            end
          end
        end

        // Error beats strobe, strobe beats timeout.
        RX_A, RX_B: begin
          if (rx_error || (!rx_strobe && (toCnt_q == TO_LIMIT))) begin
            frameError_q <= 1'b1;
            byteCnt_q    <= '0;
            toCnt_q      <= '0;
            state_q      <= IDLE;
          end else if (rx_strobe) begin
            toCnt_q <= '0;
            if (state_q == RX_A) begin
              opA_q <= (opA_q << 8) | W'(rx_data);
            end else begin
              opB_q <= (opB_q << 8) | W'(rx_data);
            end
            if (byteCnt_q == LAST_BYTE) begin
              byteCnt_q <= '0;
              state_q   <= (state_q == RX_A) ? RX_B : CALC;
            end else begin
              byteCnt_q <= byteCnt_q + 3'd1;
            end
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
          end
        end

        CALC: begin
          txByte_q  <= seqInit_d[SEQ_W-1 -: 8];
          txShift_q <= seqInit_d << 8;
          txLeft_q  <= TX_LAST;
          state_q   <= TX_LOAD;
        end

        TX_LOAD: begin
          if (!tx_busy) begin
            state_q <= TX_WAIT_HI;
          end
        end

        TX_WAIT_HI: begin
          if (tx_busy) begin
            state_q <= TX_WAIT_LO;
          end
        end

        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (txLeft_q == '0) begin
              state_q <= IDLE;
            end else begin
              txByte_q  <= txShift_q[SEQ_W-1 -: 8];
              txShift_q <= txShift_q << 8;
              txLeft_q  <= txLeft_q - 4'd1;
              state_q   <= TX_LOAD;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // Start is decoded from the registered state so the first byte goes out two clocks after the last strobe.
  assign tx_start    = (state_q == TX_LOAD) && !tx_busy;
  assign tx_data     = txByte_q;
  assign busy        = busy_q;
  assign frame_error = frameError_q;

endmodule
